// File: rtl/line_data_memory.sv
// line_data_memory: word-addressed data memory accessed one line at a time.
// Independent read and write ports, per-word write mask, wrap-around
// addressing, a 1- or 2-cycle read pipeline with a valid strobe, and an
// optional post-reset sweep that zeroes the array before ready rises.
module line_data_memory #(
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int DEPTH          = 65536,
    parameter int ADDR_W         = 32,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    output logic                               ready,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  wr_addr,
    input  logic [WORDS_PER_LINE-1:0]          wr_mask,
    input  logic [WORD_W*WORDS_PER_LINE-1:0]   wr_data,
    input  logic                               rd_en,
    input  logic [ADDR_W-1:0]                  rd_addr,
    output logic [WORD_W*WORDS_PER_LINE-1:0]   rd_data,
    output logic                               rd_valid
);

    localparam int LINE_W = WORD_W * WORDS_PER_LINE;
    localparam int AW     = $clog2(DEPTH);

    // Controller states; READY is terminal until the next reset.
    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;

    // Last line start visited by the sweep, and the per-cycle pointer step.
    localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - WORDS_PER_LINE);
    localparam logic [AW-1:0] CLR_STEP = AW'(WORDS_PER_LINE);

    // Storage array; contents are deliberately not reset.
    logic [WORD_W-1:0] mem_q [DEPTH];

    logic [1:0]        state_q,    state_d;
    logic              ready_q,    ready_d;
    logic [AW-1:0]     clr_ptr_q,  clr_ptr_d;
    logic              rd_valid_q, rd_valid_d;
    logic [LINE_W-1:0] rd_data_q,  rd_data_d;

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic [LINE_W-1:0] rd_line_s;
    logic              out_valid_s;
    logic [LINE_W-1:0] out_data_s;

    // Per-word write port seen by the array (either clear sweep or user write).
    logic [WORDS_PER_LINE-1:0] mem_we_s;
    logic [AW-1:0]             mem_waddr_s [WORDS_PER_LINE];
    logic [WORD_W-1:0]         mem_wdata_s [WORDS_PER_LINE];
    logic [AW-1:0]             rd_idx_s    [WORDS_PER_LINE];

    assign wr_acc_s = wr_en && ready_q;
    assign rd_acc_s = rd_en && ready_q;

    // Only the low AW address bits select a word; the rest are don't-care.
    generate
        if (ADDR_W > AW) begin : g_unused_addr
            logic unused_addr_s;
            assign unused_addr_s = ^{wr_addr[ADDR_W-1:AW], rd_addr[ADDR_W-1:AW]};
        end
    endgenerate

    // Controller next state: optional clear sweep, then READY forever.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            ST_RESET: begin
                if (CLEAR_ON_RESET != 0) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_CLEAR: begin
                if (clr_ptr_q == CLR_LAST) begin
                    state_d   = ST_READY;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + CLR_STEP;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d   = ST_RESET;
                clr_ptr_d = '0;
            end
        endcase
        ready_d = (state_d == ST_READY);
    end

    // Array write port: the clear sweep owns it in CLEAR, user writes in READY.
    always_comb begin
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (state_q == ST_CLEAR) begin
                mem_we_s[i]    = 1'b1;
                mem_waddr_s[i] = clr_ptr_q + AW'(i);
                mem_wdata_s[i] = '0;
            end else if (wr_acc_s) begin
                mem_we_s[i]    = wr_mask[i];
                mem_waddr_s[i] = wr_addr[AW-1:0] + AW'(i);
                mem_wdata_s[i] = wr_data[i*WORD_W +: WORD_W];
            end else begin
                mem_we_s[i]    = 1'b0;
                mem_waddr_s[i] = wr_addr[AW-1:0] + AW'(i);
                mem_wdata_s[i] = '0;
            end
        end
    end

    // Array update; words of one line are distinct addresses, so no conflicts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WORDS_PER_LINE; i++) begin
            if (mem_we_s[i]) begin
                mem_q[mem_waddr_s[i]] <= mem_wdata_s[i];
            end
        end
    end

    // Combinational line read; it sees pre-edge contents, so a same-cycle
    // write to overlapping words is not visible to this read.
    genvar g;
    generate
        for (g = 0; g < WORDS_PER_LINE; g++) begin : g_rd_word
            assign rd_idx_s[g]                   = rd_addr[AW-1:0] + AW'(g);
            assign rd_line_s[g*WORD_W +: WORD_W] = mem_q[rd_idx_s[g]];
        end
    endgenerate

    // Optional extra read stage selects the overall read latency.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic              p1_valid_q, p1_valid_d;
            logic [LINE_W-1:0] p1_data_q,  p1_data_d;

            // First stage captures the sampled line when a read is accepted.
            always_comb begin
                p1_valid_d = rd_acc_s;
                if (rd_acc_s) begin
                    p1_data_d = rd_line_s;
                end else begin
                    p1_data_d = p1_data_q;
                end
            end

            // First-stage registers; reset empties the pipeline.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    p1_valid_q <= 1'b0;
                    p1_data_q  <= '0;
                end else begin
                    p1_valid_q <= p1_valid_d;
                    p1_data_q  <= p1_data_d;
                end
            end

            assign out_valid_s = p1_valid_q;
            assign out_data_s  = p1_data_q;
        end else begin : g_lat1
            assign out_valid_s = rd_acc_s;
            assign out_data_s  = rd_line_s;
        end
    endgenerate

    // Output stage: strobe valid for one cycle, hold data otherwise.
    always_comb begin
        rd_valid_d = out_valid_s;
        if (out_valid_s) begin
            rd_data_d = out_data_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Control and output registers; reset drops ready and in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RESET;
            ready_q    <= 1'b0;
            clr_ptr_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign ready    = ready_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_line_data_memory.sv
// Bench for line_data_memory: two instances (read latency 1 and 2) share one
// stimulus stream; each has its own scoreboard queue of expected read lines.
module tb_line_data_memory;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_mask;
    logic [127:0] wr_data;
    logic         rd_en;
    logic [31:0]  rd_addr;
    logic         ready1, rv1, ready2, rv2;
    logic [127:0] rd1, rd2;

    always #5 clk = ~clk;

    line_data_memory #(.WORD_W(32), .WORDS_PER_LINE(4), .DEPTH(64), .ADDR_W(32),
                       .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .ready(ready1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd1), .rd_valid(rv1));

    line_data_memory #(.WORD_W(32), .WORDS_PER_LINE(4), .DEPTH(64), .ADDR_W(32),
                       .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut_l2 (
        .clk(clk), .rst_n(rst_n), .ready(ready2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd2), .rd_valid(rv2));

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;

    typedef struct {
        logic         we;
        logic [5:0]   wa;
        logic [3:0]   wm;
        logic [127:0] wd;
        logic         re;
        logic [5:0]   ra;
        logic [127:0] exp;
    } vec_t;

    exp_t q1[$];
    exp_t q2[$];
    vec_t vecs[13];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt1 = 0;
    int vcnt2 = 0;
    logic [127:0] last1, last2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Scoreboard for the latency-1 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            last1 = '0;
        end else begin
            if (rv1) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL l1_unexpected_valid: got rd_valid=1 at cycle %0d required 0", cyc);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    chk("l1_data", rd1, e.data);
                    chk("l1_latency", 128'(cyc), 128'(e.due));
                    vcnt1++;
                end
            end else begin
                chk("l1_hold", rd1, last1);
                if (q1.size() != 0 && q1[0].due <= cyc) begin
                    total++;
                    bad++;
                    $display("FAIL l1_missing_valid: got rd_valid=0 at cycle %0d required 1", cyc);
                    void'(q1.pop_front());
                end
            end
            last1 = rd1;
        end
    end

    // Scoreboard for the latency-2 instance.
    always @(negedge clk) begin
        if (!rst_n) begin
            last2 = '0;
        end else begin
            if (rv2) begin
                if (q2.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL l2_unexpected_valid: got rd_valid=1 at cycle %0d required 0", cyc);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    chk("l2_data", rd2, e.data);
                    chk("l2_latency", 128'(cyc), 128'(e.due));
                    vcnt2++;
                end
            end else begin
                chk("l2_hold", rd2, last2);
                if (q2.size() != 0 && q2[0].due <= cyc) begin
                    total++;
                    bad++;
                    $display("FAIL l2_missing_valid: got rd_valid=0 at cycle %0d required 1", cyc);
                    void'(q2.pop_front());
                end
            end
            last2 = rd2;
        end
    end

    // Drive one cycle of requests; an expected read line is queued for each instance.
    task automatic drive(input logic we, input logic [5:0] wa, input logic [3:0] wm,
                         input logic [127:0] wd, input logic re, input logic [5:0] ra,
                         input logic [127:0] exp);
        @(negedge clk);
        wr_en   = we;
        wr_addr = {26'd0, wa};
        wr_mask = wm;
        wr_data = wd;
        rd_en   = re;
        if (re) begin
            rd_addr = {26'd0, ra};
            q1.push_back('{exp, cyc + 1});
            q2.push_back('{exp, cyc + 2});
        end else begin
            rd_addr = 32'($urandom_range(0, 63));
        end
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 4'h0, 128'd0, 1'b0, 6'd0, 128'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && (q1.size() != 0 || q2.size() != 0); i++) begin
            idle();
        end
        chk("drain_l1", 128'(q1.size()), 128'd0);
        chk("drain_l2", 128'(q2.size()), 128'd0);
    endtask

    // Count edges after release until ready; requests are dropped once ready shows.
    task automatic wait_ready(input string nm);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!ready1 && n < 60);
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk(nm, 128'(n), 128'd17);
        chk({nm, "_l2"}, 128'(ready2), 128'd1);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_mask = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;

        vecs[0]  = '{1'b1, 6'd8,  4'hF, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, 1'b0, 6'd0, 128'd0};
        vecs[1]  = '{1'b1, 6'd8,  4'h5, {4{32'h1111}}, 1'b0, 6'd0, 128'd0};
        vecs[2]  = '{1'b0, 6'd0,  4'h0, 128'd0, 1'b1, 6'd8,
                     {32'hDDDD, 32'h1111, 32'hBBBB, 32'h1111}};
        vecs[3]  = '{1'b1, 6'd62, 4'hF, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b0, 6'd0, 128'd0};
        vecs[4]  = '{1'b0, 6'd0,  4'h0, 128'd0, 1'b1, 6'd62, {32'd4, 32'd3, 32'd2, 32'd1}};
        vecs[5]  = '{1'b0, 6'd0,  4'h0, 128'd0, 1'b1, 6'd0,  {32'd0, 32'd0, 32'd4, 32'd3}};
        vecs[6]  = '{1'b1, 6'd4,  4'hF, {4{32'h55}}, 1'b1, 6'd4, 128'd0};
        vecs[7]  = '{1'b0, 6'd0,  4'h0, 128'd0, 1'b1, 6'd4,  {4{32'h55}}};
        vecs[8]  = '{1'b0, 6'd0,  4'h0, 128'd0, 1'b1, 6'd0,  {32'd0, 32'd0, 32'd4, 32'd3}};
        vecs[9]  = '{1'b0, 6'd0,  4'h0, 128'd0, 1'b1, 6'd4,  {4{32'h55}}};
        vecs[10] = '{1'b0, 6'd0,  4'h0, 128'd0, 1'b1, 6'd8,
                     {32'hDDDD, 32'h1111, 32'hBBBB, 32'h1111}};
        vecs[11] = '{1'b1, 6'd8,  4'h0, {4{32'hFFFF_FFFF}}, 1'b0, 6'd0, 128'd0};
        vecs[12] = '{1'b0, 6'd0,  4'h0, 128'd0, 1'b1, 6'd8,
                     {32'hDDDD, 32'h1111, 32'hBBBB, 32'h1111}};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ready_l1", 128'(ready1), 128'd0);
        chk("rst_valid_l1", 128'(rv1), 128'd0);
        chk("rst_data_l1", rd1, 128'd0);
        chk("rst_ready_l2", 128'(ready2), 128'd0);
        chk("rst_valid_l2", 128'(rv2), 128'd0);
        chk("rst_data_l2", rd2, 128'd0);

        // Clear sweep: 16 lines plus one edge, then every line reads zero.
        rst_n = 1'b1;
        wait_ready("clear_edges");
        vcnt1 = 0;
        vcnt2 = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 6'd0, 4'h0, 128'd0, 1'b1, 6'(i * 4), 128'd0);
        end
        drain();
        chk("sweep_valids_l1", 128'(vcnt1), 128'd16);
        chk("sweep_valids_l2", 128'(vcnt2), 128'd16);

        // Table: masked write, wrap, collision, back-to-back reads, zero mask.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].we, vecs[i].wa, vecs[i].wm, vecs[i].wd,
                  vecs[i].re, vecs[i].ra, vecs[i].exp);
        end
        drain();

        // Reset with reads in flight: valid and ready drop at once.
        drive(1'b0, 6'd0, 4'h0, 128'd0, 1'b1, 6'd8,
              {32'hDDDD, 32'h1111, 32'hBBBB, 32'h1111});
        drive(1'b0, 6'd0, 4'h0, 128'd0, 1'b1, 6'd4, {4{32'h55}});
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q1.delete();
        q2.delete();
        wr_en   = 1'b1;
        wr_addr = 32'd8;
        wr_mask = 4'hF;
        wr_data = {4{32'h9999}};
        #1;
        chk("midrst_valid_l1", 128'(rv1), 128'd0);
        chk("midrst_valid_l2", 128'(rv2), 128'd0);
        chk("midrst_ready_l1", 128'(ready1), 128'd0);
        chk("midrst_ready_l2", 128'(ready2), 128'd0);

        // Release, interrupt the sweep, and expect a full restart.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("midclear_ready_l1", 128'(ready1), 128'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("restart_edges");

        // Array is zero again after the restarted sweep.
        drive(1'b0, 6'd0, 4'h0, 128'd0, 1'b1, 6'd8,  128'd0);
        drive(1'b0, 6'd0, 4'h0, 128'd0, 1'b1, 6'd62, 128'd0);
        drive(1'b0, 6'd0, 4'h0, 128'd0, 1'b1, 6'd4,  128'd0);
        drain();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
